if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised, decoupled instruction-fetch front end: fetch-PC register, in-order instruction-memory request/response interface, and a DEPTH-entry fetch queue between fetch and decode.
- Fetch runs ahead of a stalled decode; branch predictions are sampled at fetch time.
- EX-stage redirects flush the queue and discard stale in-flight responses.
- Sits between the instruction memory, the gshare/BTB predictor pair and the ID stage.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- DEPTH, 4, fetch-queue entries and maximum outstanding requests (power of two, ≥2).
- IDX_W, 8, predictor PHT index width carried with each entry.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= current fetch PC).
- imem_rsp_valid  in  1  in-order response, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- pred_pc  out  XLEN  PC presented to predictor/BTB (= imem_req_addr).
- pred_taken  in  1  gshare prediction for pred_pc.
- pred_hit  in  1  BTB hit for pred_pc.
- pred_target  in  XLEN  BTB target.
- pred_idx  in  IDX_W  PHT index for pred_pc.
- redirect_valid  in  1  EX misprediction/jump redirect.
- redirect_pc  in  XLEN  corrected PC.
- dq_valid  out  1  head entry holds a valid instruction.
- dq_ready  in  1  decode consumes head.
- dq_pc  out  XLEN  head PC.
- dq_instr  out  32  head instruction.
- dq_pred_taken  out  1  pred_taken AND pred_hit, as sampled at request.
- dq_pred_target  out  XLEN  predicted target, as sampled.
- dq_pred_idx  out  IDX_W  PHT index, as sampled.
- fq_count  out  clog2(DEPTH+1)  allocated entries (waiting plus filled).

Behaviour:
- Reset (rst=0, async): fetch PC=RESET_PC. Queue empty (head=tail=0, all filled flags 0). outstanding=0, drop_cnt=0. All registered outputs 0. imem_req_valid=0 while in reset.
- Request issue: imem_req_valid = !redirect_valid && fq_count<DEPTH && (drop_cnt+outstanding)<DEPTH. Combinational; no dependence on imem_req_ready.
- On request handshake (valid&&ready):
  - Allocate tail entry {PC, pred bits} and mark it unfilled; tail++ with wrap mod DEPTH; outstanding++.
  - Next fetch PC = (pred_taken&&pred_hit) ? pred_target : PC+4, wrapping mod 2^XLEN.
- No handshake: fetch PC holds.
- Response with drop_cnt≠0: data discarded; drop_cnt--.
- Response with drop_cnt=0: writes imem_rsp_data into the oldest unfilled entry and sets it filled (fill pointer++ with wrap); outstanding--. A response with drop_cnt=0 and outstanding=0 is a protocol error; assert in simulation.
- Dequeue: dq_valid = head allocated && head filled && !redirect_valid. On dq_valid&&dq_ready, head++ with wrap. dq_* fields come from the head entry register with zero combinational path from imem_rsp.
- Same-cycle events:
  - Allocate and dequeue together: fq_count unchanged.
  - Fill and dequeue of different entries: both take effect.
  - Full queue: no request. A dequeue frees the entry, and a request may issue the next cycle.
- Redirect (highest priority, single cycle):
  - Fetch PC <= redirect_pc. Queue flushed (head=tail=fill=0, count 0).
  - drop_cnt <= drop_cnt + outstanding − (imem_rsp_valid?1:0); outstanding <= 0.
  - No request and no dequeue in that cycle.
  - A request may issue the following cycle; its response is accepted only after drop_cnt returns to 0 (in-order memory guarantees this).
- Back-to-back redirects: each redirect applies the same rule; the last redirect_pc wins.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset deassertion with outstanding=0 are a memory-side protocol violation; memory is reset together with this block.
- Counters: outstanding and drop_cnt are clog2(DEPTH+1) bits and never exceed DEPTH.

Test Plan:
- Reset, imem ready=1, 1-cycle latency, no prediction, dq_ready=1 -> dq_pc sequence 0x0,0x4,0x8,… with one dq per cycle after startup; fq_count ≤2.
- dq_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued; imem_req_valid=0 while fq_count=4. On release, dq_pc 0x0..0xC in order, then fetch resumes at 0x10.
- Request at PC 0x20 with pred_taken=1, pred_hit=1, pred_target=0x100 -> next request addr 0x100. Entry 0x20 shows dq_pred_taken=1, dq_pred_target=0x100, dq_pred_idx as driven. pred_taken=1 with pred_hit=0 -> next addr 0x24.
- 3-cycle memory latency, 3 requests outstanding, redirect_pc=0x400 -> the 3 stale responses are dropped (drop_cnt 3→0). First dq_pc after the redirect is 0x400; no stale dq_valid.
- Redirect in the same cycle as a response and a full queue -> drop_cnt = outstanding−1, fq_count=0 next cycle, dq_valid=0 that cycle.
- Fetch PC 0xFFFF_FFFC, no prediction -> next request addr 0x0000_0000. Assert rst low mid-burst -> outputs cleared immediately; after release, the first request addr is RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Decoupled instruction-fetch front end: fetch PC, in-order imem request/response
// tracking and a DEPTH-entry queue feeding decode, with redirect flush.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4,
    parameter int              IDX_W    = 8,
    localparam int             CW       = $clog2(DEPTH + 1),
    localparam int             PW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [XLEN-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic             pred_hit,
    input  logic [XLEN-1:0]  pred_target,
    input  logic [IDX_W-1:0] pred_idx,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             dq_valid,
    input  logic             dq_ready,
    output logic [XLEN-1:0]  dq_pc,
    output logic [31:0]      dq_instr,
    output logic             dq_pred_taken,
    output logic [XLEN-1:0]  dq_pred_target,
    output logic [IDX_W-1:0] dq_pred_idx,
    output logic [CW-1:0]    fq_count
);

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  e_pc    [DEPTH];
    logic [31:0]      e_instr [DEPTH];
    logic [XLEN-1:0]  e_tgt   [DEPTH];
    logic [IDX_W-1:0] e_idx   [DEPTH];
    logic [DEPTH-1:0] e_taken;
    logic [DEPTH-1:0] e_filled;

    logic [PW-1:0] head, tail, fill;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic [CW:0]   inflight;

    logic req_fire, deq_fire, rsp_fill, rsp_drop, rsp_any, pred_jump;

    assign inflight  = {1'b0, drop_cnt} + {1'b0, outstanding};
    assign pred_jump = pred_taken && pred_hit;
    assign pc_next   = pred_jump ? pred_target : pc_r + XLEN'(4);

    // Request slots are bounded by both queue space and responses still owed.
    assign imem_req_valid = rst && !redirect_valid
                         && (count < CW'(DEPTH))
                         && (inflight < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc_r;
    assign pred_pc        = pc_r;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_any  = imem_rsp_valid && (inflight != '0);
    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (drop_cnt == '0)
                   && (outstanding != '0) && !redirect_valid;

    assign dq_valid = (count != '0) && e_filled[head] && !redirect_valid;
    assign deq_fire = dq_valid && dq_ready;

    assign dq_pc          = e_pc[head];
    assign dq_instr       = e_instr[head];
    assign dq_pred_taken  = e_taken[head];
    assign dq_pred_target = e_tgt[head];
    assign dq_pred_idx    = e_idx[head];
    assign fq_count       = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            pc_r        <= redirect_pc;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            outstanding <= '0;
            // Everything still owed becomes stale, minus a reply landing now.
            drop_cnt    <= drop_cnt + outstanding - CW'(rsp_any);
        end else begin
            if (req_fire) begin
                pc_r <= pc_next;
                tail <= tail + 1'b1;
            end
            if (deq_fire) head <= head + 1'b1;
            if (rsp_fill) fill <= fill + 1'b1;
            count       <= count + CW'(req_fire) - CW'(deq_fire);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fill);
            drop_cnt    <= drop_cnt - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_pc[i]    <= '0;
                e_instr[i] <= '0;
                e_tgt[i]   <= '0;
                e_idx[i]   <= '0;
            end
            e_taken  <= '0;
            e_filled <= '0;
        end else if (redirect_valid) begin
            e_filled <= '0;
        end else begin
            if (req_fire) begin
                e_pc[tail]     <= pc_r;
                e_taken[tail]  <= pred_jump;
                e_tgt[tail]    <= pred_target;
                e_idx[tail]    <= pred_idx;
                e_filled[tail] <= 1'b0;
            end
            if (rsp_fill) begin
                e_instr[fill]  <= imem_rsp_data;
                e_filled[fill] <= 1'b1;
            end
        end
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (drop_cnt != '0 || outstanding != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order, fixed-latency memory
// responder and a log of every accepted request and every dequeued entry.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic [7:0]  pred_idx;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dq_valid;
    logic        dq_ready;
    logic [31:0] dq_pc;
    logic [31:0] dq_instr;
    logic        dq_pred_taken;
    logic [31:0] dq_pred_target;
    logic [7:0]  dq_pred_idx;
    logic [2:0]  fq_count;

    logic [31:0] bpc, btarget;
    logic        btaken, bhit;
    int          lat;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] tgt;
        logic        tk;
        logic [7:0]  idx;
    } dq_t;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] req_log   [$];
    dq_t         dq_log    [$];
    int          cyc = 0;
    int          max_cnt = 0;

    if_fetch_queue #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4), .IDX_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_hit(pred_hit),
        .pred_target(pred_target), .pred_idx(pred_idx),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dq_valid(dq_valid), .dq_ready(dq_ready), .dq_pc(dq_pc),
        .dq_instr(dq_instr), .dq_pred_taken(dq_pred_taken),
        .dq_pred_target(dq_pred_target), .dq_pred_idx(dq_pred_idx),
        .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    assign pred_taken  = btaken && (pred_pc == bpc);
    assign pred_hit    = bhit && (pred_pc == bpc);
    assign pred_target = btarget;
    assign pred_idx    = pred_pc[11:4] ^ 8'hC3;

    // Memory returns ~addr as the instruction word, in order, lat cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_addr.delete();
            pend_due.delete();
            req_log.delete();
            dq_log.delete();
            max_cnt        <= 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                req_log.push_back(imem_req_addr);
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= ~pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
                imem_rsp_data  <= '0;
            end
            if (dq_valid && dq_ready)
                dq_log.push_back('{dq_pc, dq_instr, dq_pred_target,
                                   dq_pred_taken, dq_pred_idx});
            if (int'(fq_count) > max_cnt) max_cnt <= int'(fq_count);
        end
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] reqat(int i);
        if (i < req_log.size()) return req_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] dqpc(int i);
        if (i < dq_log.size()) return dq_log[i].pc;
        return 'x;
    endfunction

    function automatic logic [31:0] dqin(int i);
        if (i < dq_log.size()) return dq_log[i].instr;
        return 'x;
    endfunction

    function automatic logic [31:0] dqtk(int i);
        if (i < dq_log.size()) return 32'(dq_log[i].tk);
        return 'x;
    endfunction

    function automatic logic [31:0] dqtg(int i);
        if (i < dq_log.size()) return dq_log[i].tgt;
        return 'x;
    endfunction

    function automatic logic [31:0] dqix(int i);
        if (i < dq_log.size()) return 32'(dq_log[i].idx);
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        lat            = 1;
        dq_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bpc            = 32'h0000_0001;
        btarget        = '0;
        btaken         = 1'b0;
        bhit           = 1'b0;
        step(2);

        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_fq_count",  32'(fq_count), 32'd0);
        chk("rst_dq_valid",  32'(dq_valid), 32'd0);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        chk("rst_dq_pc",     dq_pc, 32'h0);
        chk("rst_dq_instr",  dq_instr, 32'h0);

        // Streaming with 1-cycle memory and decode always ready.
        rst = 1'b1;
        step(20);
        chk("stream_ndq", 32'(dq_log.size()), 32'd18);
        for (int i = 0; i < 8; i++) begin
            chk("stream_pc", dqpc(i), 32'(4 * i));
            chk("stream_instr", dqin(i), ~32'(4 * i));
        end
        chk("stream_maxcnt", 32'(max_cnt), 32'd2);

        // Decode stalled: queue fills to DEPTH, then drains in order.
        hold_reset();
        dq_ready = 1'b0;
        rst = 1'b1;
        step(10);
        chk("full_nreq", 32'(req_log.size()), 32'd4);
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        chk("full_count", 32'(fq_count), 32'd4);
        chk("full_dq_valid", 32'(dq_valid), 32'd1);
        chk("full_dq_pc", dq_pc, 32'h0);
        dq_ready = 1'b1;
        step(12);
        for (int i = 0; i < 5; i++)
            chk("drain_pc", dqpc(i), 32'(4 * i));
        chk("drain_resume", reqat(4), 32'h10);

        // Taken prediction with BTB hit at 0x20.
        hold_reset();
        bpc = 32'h20; btaken = 1'b1; bhit = 1'b1; btarget = 32'h100;
        rst = 1'b1;
        step(16);
        chk("pred_req8", reqat(8), 32'h20);
        chk("pred_req9", reqat(9), 32'h100);
        chk("pred_req10", reqat(10), 32'h104);
        chk("pred_dq_pc", dqpc(8), 32'h20);
        chk("pred_dq_taken", dqtk(8), 32'd1);
        chk("pred_dq_tgt", dqtg(8), 32'h100);
        chk("pred_dq_idx", dqix(8), 32'hC1);
        chk("pred_dq_instr", dqin(8), ~32'h20);
        chk("pred_prev_nt", dqtk(7), 32'd0);
        chk("pred_next_pc", dqpc(9), 32'h100);

        // Taken without BTB hit falls through.
        hold_reset();
        bhit = 1'b0;
        rst = 1'b1;
        step(12);
        chk("nohit_req9", reqat(9), 32'h24);
        chk("nohit_taken", dqtk(8), 32'd0);
        btaken = 1'b0;

        // 3-cycle memory, redirect while three requests are in flight.
        hold_reset();
        lat = 3;
        rst = 1'b1;
        step(3);
        chk("rd3_count", 32'(fq_count), 32'd3);
        chk("rd3_ndq", 32'(dq_log.size()), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        #1;
        chk("rd3_dq_valid", 32'(dq_valid), 32'd0);
        chk("rd3_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rd3_flush", 32'(fq_count), 32'd0);
        chk("rd3_req_addr", imem_req_addr, 32'h400);
        chk("rd3_req_valid2", 32'(imem_req_valid), 32'd1);
        step(10);
        chk("rd3_first_pc", dqpc(0), 32'h400);
        chk("rd3_first_instr", dqin(0), ~32'h400);
        chk("rd3_second_pc", dqpc(1), 32'h404);
        chk("rd3_second_instr", dqin(1), ~32'h404);
        chk("rd3_req3", reqat(3), 32'h400);

        // Redirect on a full queue in the same cycle as a response.
        hold_reset();
        lat = 1;
        dq_ready = 1'b0;
        rst = 1'b1;
        step(4);
        chk("rdf_count", 32'(fq_count), 32'd4);
        chk("rdf_rsp", 32'(imem_rsp_valid), 32'd1);
        chk("rdf_dq_before", 32'(dq_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h800;
        #1;
        chk("rdf_dq_valid", 32'(dq_valid), 32'd0);
        chk("rdf_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rdf_flush", 32'(fq_count), 32'd0);
        chk("rdf_req_valid2", 32'(imem_req_valid), 32'd1);
        chk("rdf_req_addr", imem_req_addr, 32'h800);
        dq_ready = 1'b1;
        step(5);
        chk("rdf_first_pc", dqpc(0), 32'h800);
        chk("rdf_first_instr", dqin(0), ~32'h800);

        // PC wrap at the top of the address space.
        hold_reset();
        rst = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        step(6);
        chk("wrap_req0", reqat(0), 32'h0);
        chk("wrap_req1", reqat(1), 32'hFFFF_FFFC);
        chk("wrap_req2", reqat(2), 32'h0);
        chk("wrap_dq0", dqpc(0), 32'hFFFF_FFFC);
        chk("wrap_dq1", dqpc(1), 32'h0);
        chk("wrap_dq1_instr", dqin(1), ~32'h0);

        // Reset asserted in the middle of the burst.
        chk("mid_busy", 32'(fq_count != 3'd0), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_count", 32'(fq_count), 32'd0);
        chk("mid_dq_valid", 32'(dq_valid), 32'd0);
        chk("mid_dq_instr", dq_instr, 32'h0);
        chk("mid_req_addr", imem_req_addr, 32'h0);
        step(2);
        rst = 1'b1;
        #1;
        chk("post_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_req_addr", imem_req_addr, 32'h0);
        step(5);
        chk("post_req0", reqat(0), 32'h0);
        chk("post_dq0", dqpc(0), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
